frv_mem_req_queue: RTL and testbench

Parametrised memory-request stage for the FRV core. It accepts load/store operations from the memory pipeline stage and issues them on the dmem bus, or completes them on the single-cycle MMIO port. Unlike a single-request LSU, it keeps up to DEPTH dmem transactions in flight and returns formatted load results and faults in program order. Entries already in flight survive a pipeline flush and are drained silently.

---
 rtl/frv_mem_req_queue.sv | 231 +++++++++++++++++++++++
 tb/tb_frv_mem_req_queue.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frv_mem_req_queue.sv
// frv_mem_req_queue: multi-outstanding load/store request stage for the FRV core.
// Latency: request path is combinational; results appear one cycle after dmem_recv,
// or one cycle after acceptance for MMIO and misaligned accesses.
// Backpressure: req_ready drops when the tracker is full, during flush, or while
// dmem_gnt is low; results stay at the head until rsp_ready.
//
// Ports: g_clk/g_resetn (sync, active-low); req_* from the memory stage;
// dmem_* in-order data bus; mmio_* single-cycle MMIO port; rsp_* in-order
// results; outstanding = occupied tracker entries.
// Optional macro FRV_MEMQ_ALIGN_CHECK_EN compiles in the misalignment trap.
module frv_mem_req_queue #(
  parameter int          DEPTH          = 2,
  parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_1000,
  parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_F000
) (
  input  logic                         g_clk,
  input  logic                         g_resetn,
  input  logic                         flush,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_load,
  input  logic                         req_store,
  input  logic [1:0]                   req_size,
  input  logic                         req_signed,
  input  logic [31:0]                  req_addr,
  input  logic [31:0]                  req_wdata,
  input  logic [4:0]                   req_rd,
  output logic                         dmem_req,
  output logic                         dmem_wen,
  output logic [3:0]                   dmem_strb,
  output logic [31:0]                  dmem_addr,
  output logic [31:0]                  dmem_wdata,
  input  logic                         dmem_gnt,
  input  logic                         dmem_recv,
  input  logic [31:0]                  dmem_rdata,
  input  logic                         dmem_error,
  output logic                         mmio_en,
  output logic                         mmio_wen,
  output logic [31:0]                  mmio_addr,
  output logic [31:0]                  mmio_wdata,
  input  logic [31:0]                  mmio_rdata,
  input  logic                         mmio_error,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [4:0]                   rsp_rd,
  output logic [31:0]                  rsp_rdata,
  output logic                         rsp_error,
  output logic                         rsp_store,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;      // byte offset already reduced to the access size
    logic        store;
    logic        occ;
    logic        filled;
    logic        flushed;
    logic        error;
    logic [31:0] data;     // raw bus word, or the trap cause when error=1
  } ent_t;

  ent_t [DEPTH-1:0] ent_q, ent_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]    outst_q, outst_d;

  logic        op_store, is_mmio, misalign, full, can_acc, mis_acc, mmio_acc, push, pop;
  logic        found;
  logic [AW-1:0] fidx;
  logic [1:0]  off;
  ent_t        new_ent, h;
  logic [31:0] sh;

  function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input int n);
    ptr_add = AW'((int'(p) + n) % DEPTH);
  endfunction

  // Cause encoding: 4/6 misaligned load/store, 5/7 bus fault load/store.
  function automatic logic [31:0] cause(input logic st, input logic bus);
    cause = {29'd0, 1'b1, st, bus};
  endfunction

  // A request flagged as both load and store is treated as a load.
  assign op_store = req_store && !req_load;
  assign is_mmio  = (req_addr & MMIO_BASE_MASK) == MMIO_BASE_ADDR;
`ifdef FRV_MEMQ_ALIGN_CHECK_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign full     = (outst_q == CW'(DEPTH));
  assign can_acc  = req_valid && !full && !flush;
  assign mis_acc  = can_acc && misalign;
  assign mmio_acc = can_acc && !misalign && is_mmio;
  assign dmem_req = can_acc && !misalign && !is_mmio;
  assign req_ready = mis_acc || mmio_acc || (dmem_req && dmem_gnt);
  assign push     = req_ready;

  assign mmio_en    = mmio_acc;
  assign mmio_wen   = mmio_acc && op_store;
  assign mmio_addr  = req_addr;
  assign mmio_wdata = req_wdata;
  assign dmem_wen   = dmem_req && op_store;
  assign dmem_addr  = {req_addr[31:2], 2'b00};

  always_comb begin
    case (req_size)
      2'b00: begin
        dmem_strb  = 4'b0001 << req_addr[1:0];
        dmem_wdata = {4{req_wdata[7:0]}};
        off        = req_addr[1:0];
      end
      2'b01: begin
        dmem_strb  = 4'b0011 << {req_addr[1], 1'b0};
        dmem_wdata = {2{req_wdata[15:0]}};
        off        = {req_addr[1], 1'b0};
      end
      default: begin
        dmem_strb  = 4'b1111;
        dmem_wdata = req_wdata;
        off        = 2'b00;
      end
    endcase
  end

  always_comb begin
    new_ent         = '0;
    new_ent.rd      = req_rd;
    new_ent.size    = req_size;
    new_ent.sgn     = req_signed;
    new_ent.off     = off;
    new_ent.store   = op_store;
    new_ent.occ     = 1'b1;
    new_ent.filled  = mis_acc || mmio_acc;
    new_ent.error   = mis_acc || (mmio_acc && mmio_error);
    if (mis_acc)
      new_ent.data = cause(op_store, 1'b0);
    else if (mmio_acc)
      new_ent.data = mmio_error ? cause(op_store, 1'b1) : mmio_rdata;
  end

  // The oldest unfilled entry owns the next dmem_recv. Prefilled MMIO or
  // misaligned entries may sit between dmem entries, so search from fill_q.
  always_comb begin
    found = 1'b0;
    fidx  = fill_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && ent_q[ptr_add(fill_q, i)].occ && !ent_q[ptr_add(fill_q, i)].filled) begin
        found = 1'b1;
        fidx  = ptr_add(fill_q, i);
      end
    end
  end

  assign h         = ent_q[head_q];
  assign rsp_valid = h.occ && h.filled && !h.flushed;
  // Flushed entries leave silently once their response has been consumed.
  assign pop       = (rsp_valid && rsp_ready) || (h.occ && h.filled && h.flushed);

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    outst_d = outst_q + CW'(push) - CW'(pop);
    if (flush)
      for (int i = 0; i < DEPTH; i++)
        if (ent_q[i].occ) ent_d[i].flushed = 1'b1;
    if (dmem_recv && found) begin
      ent_d[fidx].filled = 1'b1;
      ent_d[fidx].error  = dmem_error;
      ent_d[fidx].data   = dmem_error ? cause(ent_q[fidx].store, 1'b1) : dmem_rdata;
      fill_d             = ptr_add(fidx, 1);
    end
    if (pop) begin
      ent_d[head_q] = '0;
      head_d        = ptr_add(head_q, 1);
    end
    if (push) begin
      ent_d[tail_q] = new_ent;
      tail_d        = ptr_add(tail_q, 1);
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      outst_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      outst_q <= outst_d;
    end
  end

  assign outstanding = outst_q;
  assign sh          = h.data >> {h.off, 3'b000};

  always_comb begin
    rsp_rd    = '0;
    rsp_rdata = '0;
    rsp_error = 1'b0;
    rsp_store = 1'b0;
    if (rsp_valid) begin
      rsp_rd    = h.rd;
      rsp_error = h.error;
      rsp_store = h.store;
      if (h.error)
        rsp_rdata = h.data;
      else if (!h.store) begin
        case (h.size)
          2'b00:   rsp_rdata = {{24{h.sgn & sh[7]}}, sh[7:0]};
          2'b01:   rsp_rdata = {{16{h.sgn & sh[15]}}, sh[15:0]};
          default: rsp_rdata = sh;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frv_mem_req_queue.sv
module tb_frv_mem_req_queue;
  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        req_load = 1'b0, req_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        dmem_req, dmem_wen;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt = 1'b0, dmem_recv = 1'b0, dmem_error = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        mmio_en, mmio_wen;
  logic [31:0] mmio_addr, mmio_wdata;
  logic [31:0] mmio_rdata = '0;
  logic        mmio_error = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_rdata;
  logic        rsp_error, rsp_store;
  logic [1:0]  outstanding;

  always #5 g_clk = ~g_clk;

  frv_mem_req_queue #(.DEPTH(2)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_recv(dmem_recv),
    .dmem_rdata(dmem_rdata), .dmem_error(dmem_error), .mmio_en(mmio_en), .mmio_wen(mmio_wen),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .mmio_error(mmio_error), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .rsp_store(rsp_store),
    .outstanding(outstanding)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
    logic        st;
  } exp_t;
  exp_t sbq[$];

  task automatic sb_push(input logic [4:0] rd, input logic [31:0] rdata, input logic err,
                         input logic st);
    exp_t e;
    e.rd = rd; e.rdata = rdata; e.err = err; e.st = st;
    sbq.push_back(e);
  endtask

  // Every accepted result is compared against the oldest expectation.
  always @(negedge g_clk) begin
    if (g_resetn && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_rd", 32'(rsp_rd), 32'(e.rd));
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_error", 32'(rsp_error), 32'(e.err));
        chk("rsp_store", 32'(rsp_store), 32'(e.st));
      end
    end
  end

  typedef struct {
    logic        st;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        exp_dreq;
    logic        exp_mmio;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mkv(input logic st, input logic [1:0] size, input logic sgn,
      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
      input logic [31:0] brd, input logic berr, input logic dreq, input logic mmio,
      input logic [3:0] strb, input logic [31:0] ewd, input logic [31:0] erd,
      input logic eerr);
    vec_t v;
    v.st = st; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.bus_rdata = brd; v.bus_err = berr; v.exp_dreq = dreq; v.exp_mmio = mmio;
    v.exp_strb = strb; v.exp_wdata = ewd; v.exp_rdata = erd; v.exp_err = eerr;
    return v;
  endfunction

  task automatic drive_req(input logic st, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd);
    req_valid = 1'b1; req_load = !st; req_store = st; req_size = size;
    req_signed = sgn; req_addr = addr; req_wdata = wdata; req_rd = rd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    @(posedge g_clk); #1;
    drive_req(v.st, v.size, v.sgn, v.addr, v.wdata, v.rd);
    dmem_gnt = 1'b1; mmio_rdata = v.bus_rdata; mmio_error = v.bus_err;
    @(negedge g_clk);
    chk({s, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({s, "_dmem_req"}, 32'(dmem_req), 32'(v.exp_dreq));
    chk({s, "_mmio_en"}, 32'(mmio_en), 32'(v.exp_mmio));
    if (v.exp_dreq) begin
      chk({s, "_dmem_addr"}, dmem_addr, v.addr & 32'hFFFF_FFFC);
      chk({s, "_dmem_wen"}, 32'(dmem_wen), 32'(v.st));
      if (v.st) begin
        chk({s, "_dmem_strb"}, 32'(dmem_strb), 32'(v.exp_strb));
        chk({s, "_dmem_wdata"}, dmem_wdata, v.exp_wdata);
      end
    end
    if (v.exp_mmio) begin
      chk({s, "_mmio_addr"}, mmio_addr, v.addr);
      chk({s, "_mmio_wen"}, 32'(mmio_wen), 32'(v.st));
    end
    @(posedge g_clk);
    sb_push(v.rd, v.exp_rdata, v.exp_err, v.st);
    #1;
    req_valid = 1'b0; dmem_gnt = 1'b0; mmio_rdata = '0; mmio_error = 1'b0;
    if (v.exp_dreq) begin
      dmem_recv = 1'b1; dmem_rdata = v.bus_rdata; dmem_error = v.bus_err;
      @(negedge g_clk);
      chk({s, "_rsp_early"}, 32'(rsp_valid), 32'd0);
      @(posedge g_clk); #1;
      dmem_recv = 1'b0; dmem_error = 1'b0;
    end
    @(negedge g_clk);
    chk({s, "_rsp_latency"}, 32'(rsp_valid), 32'd1);
    @(posedge g_clk); #1;
    chk({s, "_drained"}, 32'(outstanding), 32'd0);
  endtask

  vec_t vt[12];

  initial begin
    vt[0]  = mkv(0, 2'b00, 1, 32'h2003, 32'h0,         5'd1,  32'h80FF_FFFF, 0, 1, 0, 4'h0, 32'h0,         32'hFFFF_FF80, 0);
    vt[1]  = mkv(1, 2'b01, 0, 32'h2002, 32'h0000_BEEF, 5'd2,  32'h0,         0, 1, 0, 4'hC, 32'hBEEF_BEEF, 32'h0,         0);
    vt[2]  = mkv(0, 2'b01, 0, 32'h2002, 32'h0,         5'd3,  32'h8001_0000, 0, 1, 0, 4'h0, 32'h0,         32'h0000_8001, 0);
    vt[3]  = mkv(0, 2'b01, 1, 32'h2000, 32'h0,         5'd4,  32'h0000_8001, 0, 1, 0, 4'h0, 32'h0,         32'hFFFF_8001, 0);
    vt[4]  = mkv(0, 2'b00, 0, 32'h2001, 32'h0,         5'd5,  32'h0000_AB00, 0, 1, 0, 4'h0, 32'h0,         32'h0000_00AB, 0);
    vt[5]  = mkv(1, 2'b00, 0, 32'h2001, 32'h1234_5677, 5'd6,  32'h0,         0, 1, 0, 4'h2, 32'h7777_7777, 32'h0,         0);
    vt[6]  = mkv(1, 2'b10, 0, 32'h2004, 32'hCAFE_F00D, 5'd7,  32'h0,         0, 1, 0, 4'hF, 32'hCAFE_F00D, 32'h0,         0);
    vt[7]  = mkv(0, 2'b10, 0, 32'h1004, 32'h0,         5'd8,  32'h1234_5678, 0, 0, 1, 4'h0, 32'h0,         32'h1234_5678, 0);
    vt[8]  = mkv(0, 2'b10, 0, 32'h2008, 32'h0,         5'd9,  32'h0,         1, 1, 0, 4'h0, 32'h0,         32'd5,         1);
    vt[9]  = mkv(1, 2'b10, 0, 32'h1000, 32'h0000_0001, 5'd10, 32'h0,         1, 0, 1, 4'h0, 32'h0,         32'd7,         1);
`ifdef FRV_MEMQ_ALIGN_CHECK_EN
    vt[10] = mkv(0, 2'b10, 0, 32'h2002, 32'h0,         5'd11, 32'hA5A5_5A5A, 0, 0, 0, 4'h0, 32'h0,         32'd4,         1);
    vt[11] = mkv(1, 2'b01, 0, 32'h2001, 32'h0000_1234, 5'd12, 32'h0,         0, 0, 0, 4'h0, 32'h0,         32'd6,         1);
`else
    vt[10] = mkv(0, 2'b10, 0, 32'h2002, 32'h0,         5'd11, 32'hA5A5_5A5A, 0, 1, 0, 4'h0, 32'h0,         32'hA5A5_5A5A, 0);
    vt[11] = mkv(1, 2'b01, 0, 32'h2001, 32'h0000_1234, 5'd12, 32'h0,         0, 1, 0, 4'h3, 32'h1234_1234, 32'h0,         0);
`endif

    // Reset state.
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_mmio_en", 32'(mmio_en), 32'd0);
    @(posedge g_clk); #1;
    g_resetn = 1'b1;

    // A stray dmem_recv with nothing in flight must be ignored.
    @(posedge g_clk); #1;
    dmem_recv = 1'b1; dmem_rdata = 32'h5555_5555;
    @(posedge g_clk); #1;
    dmem_recv = 1'b0;
    @(negedge g_clk);
    chk("stray_recv_outst", 32'(outstanding), 32'd0);
    chk("stray_recv_valid", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // Three back-to-back loads into a two-deep tracker with the consumer stalled.
    @(posedge g_clk); #1;
    rsp_ready = 1'b0; dmem_gnt = 1'b1;
    drive_req(0, 2'b10, 0, 32'h2010, 32'h0, 5'd13);
    @(negedge g_clk);
    chk("A_rdy0", 32'(req_ready), 32'd1);
    @(posedge g_clk);
    sb_push(5'd13, 32'h1111_1111, 0, 0);
    #1 drive_req(0, 2'b10, 0, 32'h2014, 32'h0, 5'd14);
    @(negedge g_clk);
    chk("A_rdy1", 32'(req_ready), 32'd1);
    @(posedge g_clk);
    sb_push(5'd14, 32'h2222_2222, 0, 0);
    #1 drive_req(0, 2'b10, 0, 32'h2018, 32'h0, 5'd15);
    @(negedge g_clk);
    chk("A_full_rdy", 32'(req_ready), 32'd0);
    chk("A_full_dreq", 32'(dmem_req), 32'd0);
    chk("A_full_outst", 32'(outstanding), 32'd2);
    @(posedge g_clk); #1;
    dmem_recv = 1'b1; dmem_rdata = 32'h1111_1111;
    @(negedge g_clk);
    chk("A_hold_rdy0", 32'(req_ready), 32'd0);
    @(posedge g_clk); #1;
    dmem_rdata = 32'h2222_2222;
    @(posedge g_clk); #1;
    dmem_recv = 1'b0;
    @(negedge g_clk);
    chk("A_rsp_held", 32'(rsp_valid), 32'd1);
    chk("A_hold_rdy1", 32'(req_ready), 32'd0);
    @(posedge g_clk); #1;
    rsp_ready = 1'b1;
    @(negedge g_clk);
    chk("A_pop_full_rdy", 32'(req_ready), 32'd0);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("A_third_rdy", 32'(req_ready), 32'd1);
    @(posedge g_clk);
    sb_push(5'd15, 32'h3333_3333, 0, 0);
    #1;
    chk("A_pushpop_outst", 32'(outstanding), 32'd1);
    req_valid = 1'b0; dmem_gnt = 1'b0;
    dmem_recv = 1'b1; dmem_rdata = 32'h3333_3333;
    @(posedge g_clk); #1;
    dmem_recv = 1'b0;
    @(negedge g_clk);
    chk("A_third_valid", 32'(rsp_valid), 32'd1);
    @(posedge g_clk); #1;
    chk("A_drained", 32'(outstanding), 32'd0);

    // Flush with two loads in flight: both responses are consumed silently.
    dmem_gnt = 1'b1;
    drive_req(0, 2'b10, 0, 32'h2020, 32'h0, 5'd16);
    @(posedge g_clk); #1;
    drive_req(0, 2'b10, 0, 32'h2024, 32'h0, 5'd17);
    @(posedge g_clk); #1;
    req_valid = 1'b0; dmem_gnt = 1'b0; flush = 1'b1;
    @(negedge g_clk);
    chk("B_outst2", 32'(outstanding), 32'd2);
    @(posedge g_clk); #1;
    flush = 1'b0; dmem_recv = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge g_clk);
    chk("B_novalid0", 32'(rsp_valid), 32'd0);
    @(posedge g_clk); #1;
    dmem_rdata = 32'hFEED_F00D;
    @(negedge g_clk);
    chk("B_novalid1", 32'(rsp_valid), 32'd0);
    chk("B_outst_fill1", 32'(outstanding), 32'd2);
    @(posedge g_clk); #1;
    dmem_recv = 1'b0;
    @(negedge g_clk);
    chk("B_novalid2", 32'(rsp_valid), 32'd0);
    chk("B_outst1", 32'(outstanding), 32'd1);
    @(posedge g_clk); #1;
    chk("B_outst0", 32'(outstanding), 32'd0);
    @(negedge g_clk);
    chk("B_novalid3", 32'(rsp_valid), 32'd0);

    // A request during flush must not be accepted.
    @(posedge g_clk); #1;
    flush = 1'b1; dmem_gnt = 1'b1;
    drive_req(0, 2'b10, 0, 32'h2030, 32'h0, 5'd18);
    @(negedge g_clk);
    chk("F_req_ready", 32'(req_ready), 32'd0);
    chk("F_dmem_req", 32'(dmem_req), 32'd0);
    @(posedge g_clk); #1;
    flush = 1'b0; req_valid = 1'b0; dmem_gnt = 1'b0;
    @(negedge g_clk);
    chk("F_no_push", 32'(outstanding), 32'd0);

    // Normal operation after a flush.
    run_vec(vt[0], 100);

    repeat (2) @(posedge g_clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
